// File: rtl/bist_engine_param.sv
// bist_engine_param: parametrised built-in self-test engine.
//
// Sits between the functional input bus and the circuit under test (CUT). In test mode
// an LFSR drives the CUT inputs, CUT responses are compacted into a Galois MISR, and the
// final signature is compared against a golden value.
//
// Optional feature macro: BIST_ALL_ZERO_PATTERN_EN. When defined, RUN issues one extra
// all-zeros pattern after the LFSR patterns, so the session covers NUM_PAT+1 patterns.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   testmode_i       1 = BIST mode, 0 = functional mode (dropping it aborts a session)
//   start_i          session request, honoured in IDLE/DONE only
//   func_in_i        functional CUT input
//   golden_i         expected signature, sampled in COMPARE
//   cut_resp_i       CUT response
//   cut_in_o         CUT input (pattern in test mode, func_in_i otherwise)
//   busy_o           high in RUN, FLUSH, COMPARE
//   done_o           high in DONE
//   pass_o           signature matched golden
//   fault_detected_o signature mismatched golden
//   signature_o      live MISR contents
//   pattern_idx_o    patterns issued this session
module bist_engine_param #(
  parameter int unsigned       PAT_W     = 3,
  parameter int unsigned       RESP_W    = 2,
  parameter int unsigned       SIG_W     = 4,
  parameter logic [PAT_W-1:0]  LFSR_TAPS = 3'b110,
  parameter logic [PAT_W-1:0]  LFSR_SEED = 3'b001,
  parameter logic [SIG_W-1:0]  MISR_POLY = 4'b0011,
  parameter int unsigned       RESP_LAT  = 0,
  parameter int unsigned       NUM_PAT   = 2**PAT_W - 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              testmode_i,
  input  logic              start_i,
  input  logic [PAT_W-1:0]  func_in_i,
  input  logic [SIG_W-1:0]  golden_i,
  input  logic [RESP_W-1:0] cut_resp_i,
  output logic [PAT_W-1:0]  cut_in_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              fault_detected_o,
  output logic [SIG_W-1:0]  signature_o,
  output logic [PAT_W:0]    pattern_idx_o
);

  typedef enum logic [2:0] {StIdle, StRun, StFlush, StCompare, StDone} state_e;

`ifdef BIST_ALL_ZERO_PATTERN_EN
  localparam int unsigned SessLen = NUM_PAT + 1;
`else
  localparam int unsigned SessLen = NUM_PAT;
`endif
  localparam logic [PAT_W:0] LastIdx   = (PAT_W+1)'(SessLen - 1);
  localparam logic [PAT_W:0] ZeroIdx   = (PAT_W+1)'(NUM_PAT);
  localparam logic [PAT_W:0] IdxOne    = (PAT_W+1)'(1);
  localparam logic [2:0]     FlushLast = 3'(RESP_LAT - 1);

  state_e            state_q;
  logic [PAT_W-1:0]  lfsr_q;
  logic [SIG_W-1:0]  sig_q;
  logic [PAT_W:0]    pattern_idx_q;
  logic [2:0]        flush_cnt_q;
  logic              pass_q;
  logic              fault_q;
  logic              start_q;

  logic [PAT_W-1:0]  lfsr_next;
  logic [SIG_W-1:0]  misr_next;
  logic [SIG_W-1:0]  resp_ext;
  logic              issue;
  logic              last_issue;
  logic              zero_pat;
  logic              cap_en;

  always_comb begin
    resp_ext               = '0;
    resp_ext[RESP_W-1:0]   = cut_resp_i;
    lfsr_next  = {lfsr_q[PAT_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    misr_next  = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? MISR_POLY : '0) ^ resp_ext;
    issue      = (state_q == StRun);
    last_issue = issue && (pattern_idx_q == LastIdx);
`ifdef BIST_ALL_ZERO_PATTERN_EN
    zero_pat   = issue && (pattern_idx_q == ZeroIdx);
`else
    zero_pat   = 1'b0;
`endif
  end

  // Capture enable follows issue through the CUT latency so each response lands in the MISR
  // on the edge it becomes valid.
  generate
    if (RESP_LAT == 0) begin : g_no_lat
      assign cap_en = issue;
    end else begin : g_lat
      logic [RESP_LAT-1:0] cap_pipe_q;
      always_ff @(posedge clk_i) begin
        if (rst_i || !testmode_i) begin
          cap_pipe_q <= '0;
        end else begin
          cap_pipe_q[0] <= issue;
          for (int i = 1; i < int'(RESP_LAT); i++) begin
            cap_pipe_q[i] <= cap_pipe_q[i-1];
          end
        end
      end
      assign cap_en = cap_pipe_q[RESP_LAT-1];
    end
  endgenerate

  // start is registered, so a request sampled at edge k enters RUN at edge k+1.
  always_ff @(posedge clk_i) begin
    if (rst_i || !testmode_i) begin
      state_q       <= StIdle;
      lfsr_q        <= LFSR_SEED;
      sig_q         <= '0;
      pattern_idx_q <= '0;
      flush_cnt_q   <= '0;
      pass_q        <= 1'b0;
      fault_q       <= 1'b0;
      start_q       <= 1'b0;
    end else begin
      start_q <= start_i && ((state_q == StIdle) || (state_q == StDone));
      if (cap_en) begin
        sig_q <= misr_next;
      end
      unique case (state_q)
        StIdle: begin
          lfsr_q        <= LFSR_SEED;
          sig_q         <= '0;
          pattern_idx_q <= '0;
          if (start_q) begin
            state_q <= StRun;
            start_q <= 1'b0;
          end
        end
        StRun: begin
          if (!zero_pat) begin
            lfsr_q <= lfsr_next;
          end
          pattern_idx_q <= pattern_idx_q + IdxOne;
          flush_cnt_q   <= '0;
          if (last_issue) begin
            state_q <= (RESP_LAT > 0) ? StFlush : StCompare;
          end
        end
        StFlush: begin
          if (flush_cnt_q == FlushLast) begin
            state_q <= StCompare;
          end else begin
            flush_cnt_q <= flush_cnt_q + 3'd1;
          end
        end
        StCompare: begin
          pass_q  <= (sig_q == golden_i);
          fault_q <= (sig_q != golden_i);
          state_q <= StDone;
        end
        StDone: begin
          if (start_q) begin
            lfsr_q        <= LFSR_SEED;
            sig_q         <= '0;
            pattern_idx_q <= '0;
            pass_q        <= 1'b0;
            fault_q       <= 1'b0;
            start_q       <= 1'b0;
            state_q       <= StRun;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cut_in_o         = testmode_i ? (zero_pat ? '0 : lfsr_q) : func_in_i;
  assign busy_o           = (state_q == StRun) || (state_q == StFlush) || (state_q == StCompare);
  assign done_o           = (state_q == StDone);
  assign pass_o           = pass_q;
  assign fault_detected_o = fault_q;
  assign signature_o      = sig_q;
  assign pattern_idx_o    = pattern_idx_q;

endmodule
